// File: rtl/acc_feeder.sv
// Buffers upstream words in a small FIFO and issues one word per enabled cycle to an
// accumulator input, driving zero whenever nothing is issued so the accumulator adds nothing.
module acc_feeder #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       en,
    input  logic                       flush,
    output logic [WIDTH-1:0]           acc_in,
    output logic                       acc_in_vld,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                issued
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Upstream handshake: a word transfers at a rising edge where s_valid && s_ready;
    // s_valid may be held across cycles and s_data must stay stable until the transfer.
    assign s_ready = !rst && !flush && (level != LEVEL_FULL);
    assign push    = s_valid && s_ready;
    // Pop looks only at registered occupancy, so a word pushed this edge cannot bypass.
    assign pop     = en && !flush && (level != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            issued     <= '0;
            acc_in     <= '0;
            acc_in_vld <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            issued     <= '0;
            acc_in     <= '0;
            acc_in_vld <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                issued     <= issued + 16'd1;
                acc_in     <= mem[rd_ptr];
                acc_in_vld <= 1'b1;
            end else begin
                acc_in     <= '0;
                acc_in_vld <= 1'b0;
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_feeder.sv
// Directed bench for acc_feeder: reset, streaming, backpressure, flush, counter wrap and
// mid-operation reset, each expectation worked out by hand.
module tb_acc_feeder;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic              clk;
    logic              rst;
    logic [WIDTH-1:0]  s_data;
    logic              s_valid;
    logic              s_ready;
    logic              en;
    logic              flush;
    logic [WIDTH-1:0]  acc_in;
    logic              acc_in_vld;
    logic [3:0]        level;
    logic [15:0]       issued;

    int checks = 0;
    int errors = 0;
    logic [31:0] acc_sum;

    acc_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .en         (en),
        .flush      (flush),
        .acc_in     (acc_in),
        .acc_in_vld (acc_in_vld),
        .level      (level),
        .issued     (issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream accumulator model: adds whatever acc_in carries at each edge.
    always @(posedge clk) begin
        if (rst) acc_sum <= '0;
        else     acc_sum <= acc_sum + 32'(acc_in);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int order_errs;
        logic [15:0] exp_w;

        rst = 1'b1; s_data = '0; s_valid = 1'b0; en = 1'b0; flush = 1'b0;

        // Reset held two cycles, then one idle cycle.
        tick();
        check("rst_s_ready_low", 32'(s_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_acc_in", 32'(acc_in), 32'd0);
        check("idle_vld", 32'(acc_in_vld), 32'd0);
        check("idle_level", 32'(level), 32'd0);
        check("idle_issued", 32'(issued), 32'd0);
        check("idle_s_ready", 32'(s_ready), 32'd1);

        // Stream 3,5,7 with en=1; first word must not bypass the empty FIFO.
        en = 1'b1; s_valid = 1'b1; s_data = 16'd3;
        tick();
        check("nobypass_acc_in", 32'(acc_in), 32'd0);
        check("nobypass_level", 32'(level), 32'd1);
        s_data = 16'd5;
        tick();
        check("stream_w0", 32'(acc_in), 32'd3);
        check("stream_w0_vld", 32'(acc_in_vld), 32'd1);
        check("stream_level", 32'(level), 32'd1);
        s_data = 16'd7;
        tick();
        check("stream_w1", 32'(acc_in), 32'd5);
        s_valid = 1'b0;
        tick();
        check("stream_w2", 32'(acc_in), 32'd7);
        check("stream_drained", 32'(level), 32'd0);
        tick();
        check("stream_zero", 32'(acc_in), 32'd0);
        check("stream_zero_vld", 32'(acc_in_vld), 32'd0);
        check("stream_issued", 32'(issued), 32'd3);
        check("stream_acc_sum", acc_sum, 32'd15);

        // Fill to full with en=0 (pointers wrap), 9th word held upstream.
        en = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = 16'h0100 + 16'(i);
            tick();
        end
        check("full_level", 32'(level), 32'd8);
        check("full_s_ready", 32'(s_ready), 32'd0);
        s_data = 16'h0108;
        tick();
        check("full_hold_level", 32'(level), 32'd8);
        check("full_hold_acc_in", 32'(acc_in), 32'd0);
        en = 1'b1;
        tick();
        check("full_pop_w0", 32'(acc_in), 32'h0100);
        check("full_pop_level", 32'(level), 32'd7);
        check("full_ready_after_pop", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        check("full_w1", 32'(acc_in), 32'h0101);
        check("ninth_accepted_level", 32'(level), 32'd7);
        order_errs = 0;
        for (int i = 2; i <= 8; i++) begin
            tick();
            if (acc_in !== 16'h0100 + 16'(i) || acc_in_vld !== 1'b1) order_errs++;
        end
        check("full_drain_order", 32'(order_errs), 32'd0);
        tick();
        check("full_drain_level", 32'(level), 32'd0);
        check("full_drain_vld", 32'(acc_in_vld), 32'd0);
        check("full_issued", 32'(issued), 32'd12);

        // Flush at level 4 while s_valid carries 0xAAAA and en rises.
        en = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 16'h0200 + 16'(i);
            tick();
        end
        check("preflush_level", 32'(level), 32'd4);
        flush = 1'b1; en = 1'b1; s_data = 16'hAAAA;
        #1;
        check("flush_s_ready", 32'(s_ready), 32'd0);
        tick();
        flush = 1'b0; s_valid = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_issued", 32'(issued), 32'd0);
        check("flush_acc_in", 32'(acc_in), 32'd0);
        check("flush_vld", 32'(acc_in_vld), 32'd0);
        order_errs = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (acc_in_vld !== 1'b0 || acc_in === 16'hAAAA || level !== 4'd0) order_errs++;
        end
        check("flush_nothing_leaks", 32'(order_errs), 32'd0);

        // 70000 words back to back: level pinned at 1, issued wraps to 4464.
        en = 1'b1; s_valid = 1'b1;
        order_errs = 0;
        for (int i = 0; i < 70000; i++) begin
            s_data = 16'(i);
            tick();
            if (i > 0) begin
                exp_w = 16'(i - 1);
                if (acc_in !== exp_w || acc_in_vld !== 1'b1 || level !== 4'd1) order_errs++;
            end
        end
        s_valid = 1'b0;
        check("wrap_order_and_level", 32'(order_errs), 32'd0);
        tick();
        check("wrap_last_word", 32'(acc_in), 32'(16'(69999)));
        check("wrap_level_empty", 32'(level), 32'd0);
        check("wrap_issued", 32'(issued), 32'd4464);

        // Reset mid-operation at level 5 with en=1.
        en = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 16'h0300 + 16'(i);
            tick();
        end
        check("prerst_level", 32'(level), 32'd5);
        en = 1'b1; rst = 1'b1; s_data = 16'h03FF;
        #1;
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        tick();
        check("midrst_acc_in", 32'(acc_in), 32'd0);
        check("midrst_vld", 32'(acc_in_vld), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_issued", 32'(issued), 32'd0);
        rst = 1'b0; s_data = 16'h0011;
        tick();
        s_valid = 1'b0;
        check("postrst_first_push_level", 32'(level), 32'd1);
        tick();
        check("postrst_first_word", 32'(acc_in), 32'h0011);
        check("postrst_first_vld", 32'(acc_in_vld), 32'd1);
        check("postrst_issued", 32'(issued), 32'd1);
        tick();
        check("postrst_idle", 32'(acc_in_vld), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_feeder.md
ACC_FEEDER -- requirements
Module: acc_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of every word and of acc_in.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-005 SHALL have port s_data  input  WIDTH  upstream word.
REQ-006 SHALL have port s_valid  input  1  upstream word present.
REQ-007 SHALL have port s_ready  output  1  feeder can accept; transfer when s_valid && s_ready at rising clk.
REQ-008 SHALL have port en  input  1  issue enable; low = hold FIFO, drive zero to accumulator.
REQ-009 SHALL have port flush  input  1  discard all buffered words.
REQ-010 SHALL have port acc_in  output  WIDTH  registered word to the accumulator's in port; zero when nothing is issued.
REQ-011 SHALL have port acc_in_vld  output  1  registered; high in the cycle acc_in carries a real word.
REQ-012 SHALL have port level  output  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
REQ-013 SHALL have port issued  output  16  count of words issued since reset/flush; wraps 0xFFFF->0x0000.

Function
REQ-014 SHALL buffer accepted words in a DEPTH-entry FIFO, strict first-in first-out order.
REQ-015 SHALL drive s_ready = (level != DEPTH) && !flush, combinationally from registered state.
REQ-016 SHALL pop the FIFO head at a rising edge when en=1, flush=0, level>0; the popped word is registered into acc_in with acc_in_vld=1.
REQ-017 SHALL register acc_in=0 and acc_in_vld=0 at any edge where no pop occurs, so the accumulator adds zero.
REQ-018 Latency: word accepted at edge N SHALL reach acc_in at edge N+1 at earliest (no same-edge bypass from an empty FIFO).
REQ-019 Simultaneous push and pop with 0<level<DEPTH SHALL leave level unchanged and preserve order.
REQ-020 Push when empty with en=1: level becomes 1, no pop at that edge, acc_in=0.
REQ-021 When full, s_ready=0; a pop at that edge SHALL raise s_ready in the following cycle only.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-023 issued SHALL increment by 1 at every pop edge, modulo 2^16.
REQ-024 flush=1 at an edge SHALL empty the FIFO (level=0), clear issued to 0, force acc_in=0, acc_in_vld=0, and ignore s_valid that cycle.
REQ-025 Priority at an edge: rst > flush > push/pop.
REQ-026 en toggling SHALL never drop or duplicate a word; FIFO contents persist while en=0.

Reset
REQ-027 rst=1 at an edge SHALL set level=0, pointers=0, issued=0, acc_in=0, acc_in_vld=0; FIFO storage contents are don't-care.
REQ-028 During rst=1, s_ready SHALL be 0; in-flight upstream words are discarded; operation resumes the cycle after rst falls.
REQ-029 Reset mid-operation SHALL behave identically to reset from power-up.

Verification
REQ-030 Reset held 2 cycles, then idle -> acc_in=0, acc_in_vld=0, level=0, issued=0, s_ready=1.
REQ-031 en=1, push 3,5,7 on consecutive edges -> acc_in shows 3,5,7 on the next three cycles, then 0; issued=3; downstream accumulator sum=15.
REQ-032 en=0, push 9 words (DEPTH=8) -> 8 accepted, s_ready=0 with level=8, 9th held by upstream; set en=1 -> 8 words out in order, level returns to 0, 9th accepted after first pop.
REQ-033 level=4, assert flush one cycle while s_valid=1 with data 0xAAAA -> level=0, issued=0, acc_in=0 next cycle, 0xAAAA never appears on acc_in.
REQ-034 Continuous push/pop for 70000 words -> issued wraps through 0 to 4464; no order error; level stays at 1.
REQ-035 rst asserted with level=5 and en=1 -> next cycle all outputs at reset values; pushed 0x0011 after release appears as first acc_in word.
